// File: rtl/out_dma_sched.sv
// Output stream scheduler: passes beats downstream, accumulates per-packet byte counts,
// and issues one DMA command per packet with an outstanding-command limit.
// Optional statistics counters are enabled by defining OUT_DMA_SCHED_STATS_EN.
module out_dma_sched #(
  parameter int ROWS       = 8,
  parameter int WORD_WIDTH = 8,
  parameter int W_BPT      = 16,
  parameter int BYTES_W    = 32,
  parameter int MAX_OUT    = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             en,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [ROWS*WORD_WIDTH-1:0]       s_data,
  input  logic                             s_last_pkt,
  input  logic [W_BPT-1:0]                 s_bpt,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ROWS*WORD_WIDTH-1:0]       m_data,
  output logic                             m_last,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [BYTES_W-1:0]               cmd_bytes,
  input  logic                             done,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
  output logic                             err,
  output logic [31:0]                      pkt_count,
  output logic [31:0]                      beat_count
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = ((BYTES_W > W_BPT) ? BYTES_W : W_BPT) + 1;
  localparam logic [OW-1:0] MAX_OUT_W = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CMD,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [BYTES_W-1:0] acc_q, acc_d;
  logic [BYTES_W-1:0] cmd_bytes_q, cmd_bytes_d;
  logic [OW-1:0]      out_q, out_d;
  logic               err_q, err_d;

  logic               gate;
  logic               fire;
  logic               cmd_hs;
  logic [SW-1:0]      sum;
  logic               ovf;
  logic [BYTES_W-1:0] sum_sat;

  // Gating with aresetn keeps the handshakes closed while reset is held.
  assign gate      = aresetn & (state_q == STREAM);
  assign s_ready   = m_ready & gate;
  assign m_valid   = s_valid & gate;
  assign m_data    = s_data;
  assign m_last    = s_last_pkt;
  assign cmd_valid = aresetn & (state_q == CMD);

  assign fire      = s_valid & s_ready;
  assign cmd_hs    = cmd_valid & cmd_ready;

  assign sum       = SW'(acc_q) + SW'(s_bpt);
  assign ovf       = |sum[SW-1:BYTES_W];
  assign sum_sat   = ovf ? '1 : sum[BYTES_W-1:0];

  assign cmd_bytes   = cmd_bytes_q;
  assign outstanding = out_q;
  assign err         = err_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cmd_bytes_d = cmd_bytes_q;
    out_d       = out_q;
    err_d       = err_q;

    if (fire) begin
      if (ovf) err_d = 1'b1;
      if (s_last_pkt) begin
        cmd_bytes_d = sum_sat;
        acc_d       = '0;
      end else begin
        acc_d = sum_sat;
      end
    end

    // A simultaneous issue and completion cancel out.
    unique case ({cmd_hs, done})
      2'b10: out_d = out_q + OW'(1);
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - OW'(1);
      end
      default: out_d = out_q;
    endcase

    unique case (state_q)
      IDLE:    if (en) state_d = STREAM;
      STREAM:  if (fire && s_last_pkt) state_d = CMD;
      CMD:     if (cmd_ready) state_d = (out_d < MAX_OUT_W) ? STREAM : HOLD;
      HOLD:    if (out_d < MAX_OUT_W) state_d = STREAM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cmd_bytes_q <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cmd_bytes_q <= cmd_bytes_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

`ifdef OUT_DMA_SCHED_STATS_EN
  logic [31:0] pkt_q, beat_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_q  <= '0;
      beat_q <= '0;
    end else begin
      if (cmd_hs) pkt_q  <= pkt_q + 32'd1;
      if (fire)   beat_q <= beat_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_q;
  assign beat_count = beat_q;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: doc/out_dma_sched.md
OUT_DMA_SCHED -- requirements
Module: out_dma_sched

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- ROWS, 8, words per beat.
- WORD_WIDTH, 8, bits per word.
- W_BPT, 16, width of the bytes-per-transfer field.
- BYTES_W, 32, width of the packet byte count.
- MAX_OUT, 4, maximum DMA commands outstanding (at least 1).
REQ-002 The block SHALL expose these ports (name, direction, width, meaning), clock and reset first:
- aclk, in, 1, clock.
- aresetn, in, 1, reset: synchronous, active-low, on aclk.
- en, in, 1, level enable for leaving IDLE.
- s_valid, in, 1, upstream beat valid.
- s_ready, out, 1, upstream beat ready.
- s_data, in, ROWS*WORD_WIDTH, upstream beat data.
- s_last_pkt, in, 1, final beat of a packet.
- s_bpt, in, W_BPT, bytes carried by the current beat.
- m_valid, out, 1, downstream beat valid.
- m_ready, in, 1, downstream beat ready.
- m_data, out, ROWS*WORD_WIDTH, downstream beat data.
- m_last, out, 1, downstream packet end.
- cmd_valid, out, 1, DMA command valid.
- cmd_ready, in, 1, DMA command accept.
- cmd_bytes, out, BYTES_W, packet byte count.
- done, in, 1, one-cycle DMA completion pulse.
- outstanding, out, $clog2(MAX_OUT+1), commands in flight.
- err, out, 1, sticky error flag.
- pkt_count, out, 32, packet statistics counter.
- beat_count, out, 32, beat statistics counter.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, STREAM, CMD and HOLD.
REQ-004 The gate SHALL be open only in STREAM.
REQ-005 The data path SHALL have zero latency: m_valid = s_valid & gate, s_ready = m_ready & gate, m_data = s_data, m_last = s_last_pkt.
REQ-006 A beat fires when s_valid & s_ready; only fired beats SHALL affect internal state.
REQ-007 The accumulator acc (BYTES_W bits) SHALL add the zero-extended s_bpt on every fired beat.
REQ-008 If an addition would exceed 2^BYTES_W-1, acc SHALL saturate at all-ones and err SHALL be set.
REQ-009 On a fired beat with s_last_pkt=1, the block SHALL, on the next edge:
- load cmd_bytes with acc+s_bpt (saturated);
- clear acc to 0;
- enter CMD.
REQ-010 In CMD, cmd_valid SHALL be 1 and cmd_bytes SHALL be held stable until cmd_ready=1; cmd_valid SHALL be 0 in all other states.
REQ-011 On the CMD handshake, outstanding SHALL increment, and the next state SHALL be STREAM if the new outstanding < MAX_OUT, otherwise HOLD.
REQ-012 HOLD SHALL go to STREAM in the cycle after outstanding drops below MAX_OUT.
REQ-013 IDLE SHALL go to STREAM when en=1; en=0 SHALL NOT affect any state other than IDLE.
REQ-014 done=1 SHALL decrement outstanding.
REQ-015 done=1 while outstanding=0 SHALL leave outstanding at 0 and set err.
REQ-016 A CMD handshake and done in the same cycle SHALL leave outstanding unchanged.
REQ-017 A zero-byte packet (a single last beat with s_bpt=0) SHALL still issue a command with cmd_bytes=0.
REQ-018 Once set, err SHALL clear only on reset.

Reset
REQ-019 When aresetn=0 at a rising edge of aclk, the block SHALL enter IDLE with acc=0, cmd_bytes=0, outstanding=0, err=0, pkt_count=0 and beat_count=0.
REQ-020 In reset and in IDLE, s_ready, m_valid and cmd_valid SHALL be 0.
REQ-021 A reset mid-packet or mid-CMD SHALL drop the partial count and the pending command, with no command emitted.

Configuration
REQ-022 With OUT_DMA_SCHED_STATS_EN defined, the statistics counters SHALL be active:
- pkt_count SHALL increment on each CMD handshake.
- beat_count SHALL increment on each fired beat.
- Both SHALL wrap modulo 2^32.
REQ-023 Without OUT_DMA_SCHED_STATS_EN, pkt_count and beat_count SHALL be tied to 0 and no counter flops SHALL be inferred.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- en=1, 3 beats with s_bpt=64,64,32, last on the third -> cmd_bytes=160 one cycle later, acc=0, outstanding=1.
- MAX_OUT=2, two packets with cmd_ready=1 and no done -> HOLD, s_ready=0; one done pulse -> STREAM on the next cycle.
- In CMD, cmd_ready low for 5 cycles -> cmd_valid=1 and cmd_bytes stable throughout, no beat fires.
- CMD handshake and done in the same cycle with outstanding=1 -> outstanding stays 1.
- done with outstanding=0 -> err=1 and stays 1; BYTES_W=8 with beats of 200 and 100 -> cmd_bytes=255 and err=1.
- Reset asserted after 2 beats of a packet -> IDLE, no cmd_valid, acc=0; with the macro defined, beat_count=0.
